// File: rtl/lms_pkg.sv
// Shared constants and types for the LMS coefficient-update stage.
package lms_pkg;

  localparam int NTAPS    = 16;
  localparam int REF_W    = 14;
  localparam int ERR_W    = 10;
  localparam int WGT_W    = 31;
  localparam int MU_SHIFT = 8;

  localparam logic signed [WGT_W-1:0] WGT_MAX = {1'b0, {(WGT_W-1){1'b1}}};
  localparam logic signed [WGT_W-1:0] WGT_MIN = {1'b1, {(WGT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    DONE
  } state_t;

endpackage

// File: rtl/lms_tap_mac.sv
// Single shared multiply-accumulate for one tap: w + ((e*ref) >>> MU_SHIFT), saturated to WGT_W bits.
module lms_tap_mac #(
  parameter int REF_W    = 14,
  parameter int ERR_W    = 10,
  parameter int WGT_W    = 31,
  parameter int MU_SHIFT = 8
) (
  input  logic signed [ERR_W-1:0] e_q,
  input  logic signed [REF_W-1:0] ref_tap,
  input  logic signed [WGT_W-1:0] w_old,
  output logic signed [WGT_W-1:0] w_new,
  output logic                    sat
);

  localparam int PW = ERR_W + REF_W;

  logic signed [PW-1:0]  prod;
  logic signed [PW-1:0]  shifted;
  logic signed [WGT_W:0] delta;
  logic signed [WGT_W:0] sum;

  // One guard bit above the weight width: the top two bits disagree exactly when the sum left range
  always_comb begin
    prod    = PW'(e_q) * PW'(ref_tap);
    shifted = prod >>> MU_SHIFT;
    delta   = (WGT_W+1)'(shifted);
    sum     = (WGT_W+1)'(w_old) + delta;
    sat     = sum[WGT_W] ^ sum[WGT_W-1];
    w_new   = sum[WGT_W-1:0];
    if (sat) begin
      w_new = sum[WGT_W] ? {1'b1, {(WGT_W-1){1'b0}}} : {1'b0, {(WGT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/lms_weight_update.sv
// LMS weight-update stage: one tap per clock through a shared MAC, with burst control and sticky flags.
module lms_weight_update #(
  parameter int NTAPS    = lms_pkg::NTAPS,
  parameter int REF_W    = lms_pkg::REF_W,
  parameter int ERR_W    = lms_pkg::ERR_W,
  parameter int WGT_W    = lms_pkg::WGT_W,
  parameter int MU_SHIFT = lms_pkg::MU_SHIFT
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     upd_en,
  input  logic                     weight_clr,
  input  logic                     e_valid,
  input  logic [ERR_W-1:0]         e,
  input  logic [NTAPS*REF_W-1:0]   ref_flat,
  output logic [NTAPS*WGT_W-1:0]   weight_flat,
  output logic                     busy,
  output logic                     upd_done,
  output logic                     sat_flag,
  output logic                     overrun
);

  import lms_pkg::*;

  localparam int IDX_W = $clog2(NTAPS);

  state_t                          state;
  state_t                          state_nxt;
  logic [IDX_W-1:0]                idx;
  logic signed [ERR_W-1:0]         e_q;
  logic [NTAPS-1:0][REF_W-1:0]     ref_q;
  logic [NTAPS-1:0][WGT_W-1:0]     w;

  logic                            start;
  logic                            clr;
  logic                            wr_en;
  logic                            abort;
  logic                            ovr_set;
  logic                            done_set;
  logic signed [WGT_W-1:0]         w_new;
  logic                            mac_sat;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // An abort takes priority over finishing the last tap
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (e_valid && upd_en && !weight_clr) state_nxt = UPDATE;
      UPDATE: begin
        if (!upd_en)                              state_nxt = IDLE;
        else if (idx == IDX_W'(NTAPS-1))          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start    = (state == IDLE) && e_valid && upd_en && !weight_clr;
    clr      = (state == IDLE) && weight_clr;
    wr_en    = (state == UPDATE) && upd_en;
    abort    = (state == UPDATE) && !upd_en;
    ovr_set  = (state != IDLE) && e_valid;
    done_set = (state == DONE);
  end

  lms_tap_mac #(
    .REF_W    (REF_W),
    .ERR_W    (ERR_W),
    .WGT_W    (WGT_W),
    .MU_SHIFT (MU_SHIFT)
  ) u_mac (
    .e_q     (e_q),
    .ref_tap ($signed(ref_q[idx])),
    .w_old   ($signed(w[idx])),
    .w_new   (w_new),
    .sat     (mac_sat)
  );

  // The error and taps are snapshotted at acceptance so the inputs are free to move during a burst
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy     <= 1'b0;
      upd_done <= 1'b0;
      sat_flag <= 1'b0;
      overrun  <= 1'b0;
      idx      <= '0;
      e_q      <= '0;
      ref_q    <= '0;
    end else begin
      upd_done <= done_set;
      if (start) begin
        busy  <= 1'b1;
        idx   <= '0;
        e_q   <= e;
        ref_q <= ref_flat;
      end else if (done_set || abort) begin
        busy  <= 1'b0;
      end
      if (wr_en) idx <= idx + IDX_W'(1);
      if (clr) begin
        sat_flag <= 1'b0;
        overrun  <= 1'b0;
      end else begin
        if (wr_en && mac_sat) sat_flag <= 1'b1;
        if (ovr_set)          overrun  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      w      <= '0;
    else if (clr)   w      <= '0;
    else if (wr_en) w[idx] <= w_new;
  end

  assign weight_flat = w;

endmodule
